// File: rtl/argon_regfile_sequencer.sv
// Bus initiator for the Argon register file: issues LATCHSEL -> READA -> READB for an
// operand request, returns both operands, and writes results back to register C via LATCHC.
module argon_regfile_sequencer #(
  parameter int                   WORD_WIDTH   = 16,
  parameter int                   INDEX_WIDTH  = 3,
  parameter int                   CMD_WIDTH    = 4,
  parameter logic [CMD_WIDTH-1:0] IDLE_COMMAND = '0
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic [INDEX_WIDTH-1:0] i_idxA,
  input  logic [INDEX_WIDTH-1:0] i_idxB,
  input  logic [INDEX_WIDTH-1:0] i_idxC,
  output logic                   o_rsp_valid,
  input  logic                   i_rsp_ready,
  output logic [WORD_WIDTH-1:0]  o_opA,
  output logic [WORD_WIDTH-1:0]  o_opB,
  input  logic                   i_wb_valid,
  output logic                   o_wb_ready,
  input  logic [WORD_WIDTH-1:0]  i_wb_data,
  output logic [CMD_WIDTH-1:0]   o_bus_command,
  output logic                   o_bus_valid,
  output logic [WORD_WIDTH-1:0]  o_bus_data,
  input  logic [WORD_WIDTH-1:0]  i_bus_data,
  input  logic                   i_bus_valid,
  output logic                   o_bus_err
);

  localparam logic [CMD_WIDTH-1:0] COM_LATCHSEL = CMD_WIDTH'(1);
  localparam logic [CMD_WIDTH-1:0] COM_READA    = CMD_WIDTH'(2);
  localparam logic [CMD_WIDTH-1:0] COM_READB    = CMD_WIDTH'(3);
  localparam logic [CMD_WIDTH-1:0] COM_LATCHC   = CMD_WIDTH'(4);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SEL  = 3'd1,
    S_RDA  = 3'd2,
    S_RDB  = 3'd3,
    S_RSP  = 3'd4,
    S_WB   = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] idx_a_q, idx_a_d, idx_b_q, idx_b_d, idx_c_q, idx_c_d;
  logic [WORD_WIDTH-1:0]  wb_data_q, wb_data_d;
  logic [WORD_WIDTH-1:0]  op_a_q, op_a_d, op_b_q, op_b_d;
  logic [CMD_WIDTH-1:0]   cmd_q, cmd_d;
  logic                   bus_valid_q, bus_valid_d;
  logic [WORD_WIDTH-1:0]  bus_data_q, bus_data_d;
  logic                   err_q, err_d;
  logic                   req_ready_q, req_ready_d;
  logic                   wb_ready_q, wb_ready_d;
  logic                   rsp_valid_q, rsp_valid_d;

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q     <= S_IDLE;
      idx_a_q     <= '0;
      idx_b_q     <= '0;
      idx_c_q     <= '0;
      wb_data_q   <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      cmd_q       <= IDLE_COMMAND;
      bus_valid_q <= 1'b0;
      bus_data_q  <= '0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b0;
      wb_ready_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_a_q     <= idx_a_d;
      idx_b_q     <= idx_b_d;
      idx_c_q     <= idx_c_d;
      wb_data_q   <= wb_data_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      cmd_q       <= cmd_d;
      bus_valid_q <= bus_valid_d;
      bus_data_q  <= bus_data_d;
      err_q       <= err_d;
      req_ready_q <= req_ready_d;
      wb_ready_q  <= wb_ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_a_d   = idx_a_q;
    idx_b_d   = idx_b_q;
    idx_c_d   = idx_c_q;
    wb_data_d = wb_data_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Writeback has priority; a simultaneous request stays pending on its valid.
        if (i_wb_valid && wb_ready_q) begin
          wb_data_d = i_wb_data;
          state_d   = S_WB;
        end else if (i_req_valid && req_ready_q) begin
          idx_a_d = i_idxA;
          idx_b_d = i_idxB;
          idx_c_d = i_idxC;
          state_d = S_SEL;
        end
      end
      S_SEL: state_d = S_RDA;
      S_RDA: begin
        op_a_d  = i_bus_valid ? i_bus_data : '0;
        err_d   = ~i_bus_valid;
        state_d = S_RDB;
      end
      S_RDB: begin
        op_b_d  = i_bus_valid ? i_bus_data : '0;
        err_d   = ~i_bus_valid;
        state_d = S_RSP;
      end
      S_RSP:   if (i_rsp_ready) state_d = S_IDLE;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with the state they describe.
    cmd_d       = IDLE_COMMAND;
    bus_valid_d = 1'b0;
    bus_data_d  = '0;
    case (state_d)
      S_SEL: begin
        cmd_d       = COM_LATCHSEL;
        bus_valid_d = 1'b1;
        bus_data_d  = WORD_WIDTH'({idx_c_d, idx_b_d, idx_a_d});
      end
      S_RDA: cmd_d = COM_READA;
      S_RDB: cmd_d = COM_READB;
      S_WB: begin
        cmd_d       = COM_LATCHC;
        bus_valid_d = 1'b1;
        bus_data_d  = wb_data_d;
      end
      default: cmd_d = IDLE_COMMAND;
    endcase
    req_ready_d = (state_d == S_IDLE);
    wb_ready_d  = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RSP);
  end

  assign o_req_ready   = req_ready_q;
  assign o_wb_ready    = wb_ready_q;
  assign o_rsp_valid   = rsp_valid_q;
  assign o_opA         = op_a_q;
  assign o_opB         = op_b_q;
  assign o_bus_command = cmd_q;
  assign o_bus_valid   = bus_valid_q;
  assign o_bus_data    = bus_data_q;
  assign o_bus_err     = err_q;

endmodule

// File: tb/tb_argon_regfile_sequencer.sv
// Bench for argon_regfile_sequencer: a behavioural regfile on the bus, and a scoreboard of
// expected operand pairs pushed at request time and popped when the response is taken.
module tb_argon_regfile_sequencer;

  localparam logic [3:0] C_IDLE = 4'd0, C_LSEL = 4'd1, C_RDA = 4'd2, C_RDB = 4'd3, C_LC = 4'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid = 1'b0, req_ready;
  logic [2:0]  idx_a = '0, idx_b = '0, idx_c = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [15:0] op_a, op_b;
  logic        wb_valid = 1'b0, wb_ready;
  logic [15:0] wb_data = '0;
  logic [3:0]  bus_cmd;
  logic        bus_valid_o;
  logic [15:0] bus_data_o;
  logic [15:0] bus_data_i;
  logic        bus_valid_i;
  logic        bus_err;
  logic        force_inv = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] sb_q[$];
  logic [15:0] shadow[8];
  logic [2:0]  last_c = '0;

  argon_regfile_sequencer dut (
    .i_Clk(clk), .i_Reset(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_idxA(idx_a), .i_idxB(idx_b), .i_idxC(idx_c),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_opA(op_a), .o_opB(op_b),
    .i_wb_valid(wb_valid), .o_wb_ready(wb_ready), .i_wb_data(wb_data),
    .o_bus_command(bus_cmd), .o_bus_valid(bus_valid_o), .o_bus_data(bus_data_o),
    .i_bus_data(bus_data_i), .i_bus_valid(bus_valid_i), .o_bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // Behavioural regfile: combinational reads, latched selects, register 0 not writable.
  logic [15:0] rf[8];
  logic [2:0]  rf_a = '0, rf_b = '0, rf_c = '0;
  always_comb begin
    bus_data_i  = '0;
    bus_valid_i = 1'b0;
    if (bus_cmd == C_RDA) begin
      bus_data_i  = rf[rf_a];
      bus_valid_i = ~force_inv;
    end else if (bus_cmd == C_RDB) begin
      bus_data_i  = rf[rf_b];
      bus_valid_i = ~force_inv;
    end
  end
  always @(posedge clk) begin
    if (bus_cmd == C_LSEL && bus_valid_o) begin
      rf_a <= bus_data_o[2:0];
      rf_b <= bus_data_o[5:3];
      rf_c <= bus_data_o[8:6];
    end else if (bus_cmd == C_LC && bus_valid_o && rf_c != 3'd0) begin
      rf[rf_c] <= bus_data_o;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic push_req(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                          input bit bad_b);
    logic [15:0] eb;
    eb = bad_b ? 16'h0000 : shadow[b];
    sb_q.push_back({shadow[a], eb});
    last_c = c;
  endtask

  task automatic pop_check();
    logic [31:0] e;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check("opA", {16'h0, op_a}, {16'h0, e[31:16]});
      check("opB", {16'h0, op_b}, {16'h0, e[15:0]});
    end
  endtask

  task automatic run_req(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                         input int hold, input bit bad_b);
    wait_idle();
    req_valid = 1'b1; idx_a = a; idx_b = b; idx_c = c;
    push_req(a, b, c, bad_b);
    @(negedge clk);
    req_valid = 1'b0;
    check("sel_cmd", {28'h0, bus_cmd}, {28'h0, C_LSEL});
    check("sel_valid", {31'h0, bus_valid_o}, 32'd1);
    check("sel_data", {16'h0, bus_data_o}, {23'h0, c, b, a});
    check("sel_ready", {31'h0, req_ready}, 32'd0);
    @(negedge clk);
    check("rda_cmd", {28'h0, bus_cmd}, {28'h0, C_RDA});
    check("rda_valid", {31'h0, bus_valid_o}, 32'd0);
    @(negedge clk);
    check("rdb_cmd", {28'h0, bus_cmd}, {28'h0, C_RDB});
    force_inv = bad_b;
    @(negedge clk);
    force_inv = 1'b0;
    check("rsp_valid", {31'h0, rsp_valid}, 32'd1);
    check("bus_err", {31'h0, bus_err}, {31'h0, bad_b});
    pop_check();
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", {31'h0, rsp_valid}, 32'd1);
      check("hold_ops", {op_a, op_b}, {shadow[a], bad_b ? 16'h0 : shadow[b]});
      check("hold_bus", {27'h0, bus_cmd, bus_valid_o}, {27'h0, C_IDLE, 1'b0});
      check("hold_ready", {30'h0, req_ready, wb_ready}, 32'd0);
      check("hold_err", {31'h0, bus_err}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_drop", {31'h0, rsp_valid}, 32'd0);
    check("ready_back", {30'h0, req_ready, wb_ready}, 32'd3);
  endtask

  task automatic run_wb(input logic [15:0] d);
    wait_idle();
    wb_valid = 1'b1; wb_data = d;
    if (last_c != 3'd0) shadow[last_c] = d;
    @(negedge clk);
    wb_valid = 1'b0;
    check("wb_cmd", {28'h0, bus_cmd}, {28'h0, C_LC});
    check("wb_valid", {31'h0, bus_valid_o}, 32'd1);
    check("wb_data", {16'h0, bus_data_o}, {16'h0, d});
    @(negedge clk);
    check("wb_done", {28'h0, bus_cmd}, {28'h0, C_IDLE});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      rf[i]     = 16'h1000 + 16'(i * 16'h0111);
      shadow[i] = rf[i];
    end
    rf[0] = 16'h0;     shadow[0] = 16'h0;
    rf[1] = 16'h1234;  shadow[1] = 16'h1234;
    rf[2] = 16'hBEEF;  shadow[2] = 16'hBEEF;

    rst = 1'b1;
    #12;
    check("rst_cmd", {28'h0, bus_cmd}, {28'h0, C_IDLE});
    check("rst_outs", {26'h0, req_ready, wb_ready, rsp_valid, bus_valid_o, bus_err, 1'b0}, 32'd0);
    check("rst_ops", {op_a, op_b}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", {30'h0, req_ready, wb_ready}, 32'd3);
    check("idle_bus", {16'h0, bus_data_o}, 32'd0);

    run_req(3'd1, 3'd2, 3'd3, 0, 1'b0);
    run_req(3'd2, 3'd1, 3'd5, 10, 1'b0);
    run_req(3'd1, 3'd2, 3'd3, 0, 1'b0);
    run_wb(16'hA5A5);
    run_req(3'd3, 3'd6, 3'd7, 0, 1'b0);
    run_req(3'd4, 3'd5, 3'd0, 0, 1'b0);
    run_wb(16'h7777);
    run_req(3'd0, 3'd7, 3'd2, 0, 1'b0);
    run_req(3'd1, 3'd2, 3'd3, 2, 1'b1);

    // Writeback and request together: LATCHC goes first, then the pending request.
    wait_idle();
    wb_valid = 1'b1; wb_data = 16'h5A5A;
    if (last_c != 3'd0) shadow[last_c] = 16'h5A5A;
    req_valid = 1'b1; idx_a = 3'd3; idx_b = 3'd4; idx_c = 3'd6;
    push_req(3'd3, 3'd4, 3'd6, 1'b0);
    @(negedge clk);
    wb_valid = 1'b0;
    check("sim_wb_cmd", {28'h0, bus_cmd}, {28'h0, C_LC});
    check("sim_wb_data", {16'h0, bus_data_o}, 32'h5A5A);
    check("sim_ready", {31'h0, req_ready}, 32'd0);
    @(negedge clk);
    check("sim_idle", {31'h0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check("sim_sel_cmd", {28'h0, bus_cmd}, {28'h0, C_LSEL});
    check("sim_sel_data", {16'h0, bus_data_o}, {23'h0, 3'd6, 3'd4, 3'd3});
    repeat (3) @(negedge clk);
    check("sim_rsp", {31'h0, rsp_valid}, 32'd1);
    pop_check();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Asynchronous reset in the middle of RDA.
    wait_idle();
    req_valid = 1'b1; idx_a = 3'd1; idx_b = 3'd2; idx_c = 3'd3;
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #2;
    check("pre_rst_cmd", {28'h0, bus_cmd}, {28'h0, C_RDA});
    rst = 1'b1;
    #1;
    check("arst_cmd", {28'h0, bus_cmd}, {28'h0, C_IDLE});
    check("arst_outs", {27'h0, req_ready, wb_ready, rsp_valid, bus_valid_o, bus_err}, 32'd0);
    check("arst_ops", {op_a, op_b}, 32'd0);
    check("arst_data", {16'h0, bus_data_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {30'h0, req_ready, wb_ready}, 32'd3);
    @(negedge clk);
    check("post_rst_idle", {28'h0, bus_cmd}, {28'h0, C_IDLE});
    run_req(3'd2, 3'd3, 3'd1, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
